// File: rtl/jt51_opacc.sv
// Operator output accumulator: gathers carrier operator samples per channel, mixes them
// onto the left/right buses and emits one saturated stereo sample per 32-slot frame.
module jt51_opacc #(
  parameter int unsigned ACCW = 20,
  parameter int unsigned OUTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            zero,
  input  logic [13:0]     op_in,
  input  logic [2:0]      con_in,
  input  logic [1:0]      rl_in,
  output logic [OUTW-1:0] left,
  output logic [OUTW-1:0] right,
  output logic            sample
);

  localparam logic signed [ACCW-1:0] SatHi = ACCW'((1 << (OUTW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SatLo = -SatHi - 1;

  logic [4:0]             slot_q, cur;
  logic [1:0]             grp;
  logic [2:0]             ch;
  logic                   locked_q, active;
  logic [3:0]             mask;
  logic signed [15:0]     chacc_q [8];
  logic signed [15:0]     term, fin;
  logic signed [ACCW-1:0] fin_ext, lsum_q, rsum_q, lsum_d, rsum_d;
  logic [OUTW-1:0]        left_q, right_q;
  logic                   sample_q;

  function automatic logic [OUTW-1:0] sat(input logic signed [ACCW-1:0] v);
    if (v > SatHi) return SatHi[OUTW-1:0];
    if (v < SatLo) return SatLo[OUTW-1:0];
    return v[OUTW-1:0];
  endfunction

  always_comb begin
    active  = zero | locked_q;
    cur     = zero ? 5'd0 : slot_q + 5'd1;
    grp     = cur[4:3];
    ch      = cur[2:0];
    // Carrier mask indexed by group: bit0=M1, bit1=M2, bit2=C1, bit3=C2
    case (con_in)
      3'd4:       mask = 4'b1100;
      3'd5, 3'd6: mask = 4'b1110;
      3'd7:       mask = 4'b1111;
      default:    mask = 4'b1000;
    endcase
    term    = mask[grp] ? {{2{op_in[13]}}, op_in} : 16'sd0;
    fin     = chacc_q[ch] + term;
    fin_ext = {{(ACCW - 16){fin[15]}}, fin};
    lsum_d  = lsum_q;
    rsum_d  = rsum_q;
    if (grp == 2'd3) begin
      // Slot 24 starts a fresh frame sum, so a resync never leaks old partial sums
      lsum_d = ((ch == 3'd0) ? '0 : lsum_q) + (rl_in[1] ? fin_ext : '0);
      rsum_d = ((ch == 3'd0) ? '0 : rsum_q) + (rl_in[0] ? fin_ext : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      locked_q <= 1'b0;
      lsum_q   <= '0;
      rsum_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      for (int i = 0; i < 8; i++) chacc_q[i] <= '0;
    end else if (cen) begin
      sample_q <= 1'b0;
      if (active) begin
        locked_q <= 1'b1;
        slot_q   <= cur;
        unique case (grp)
          2'd0:       chacc_q[ch] <= term;
          2'd1, 2'd2: chacc_q[ch] <= fin;
          2'd3: begin
            lsum_q <= lsum_d;
            rsum_q <= rsum_d;
          end
        endcase
        if (cur == 5'd31) begin
          left_q   <= sat(lsum_d);
          right_q  <= sat(rsum_d);
          sample_q <= 1'b1;
        end
      end
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q & cen;

endmodule

// File: tb/tb_jt51_opacc.sv
// Self-checking bench for jt51_opacc: frame-level mixing model plus directed frames.
module tb_jt51_opacc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cen = 1'b0;
  logic        zero = 1'b0;
  logic [13:0] op_in = '0;
  logic [2:0]  con_in = '0;
  logic [1:0]  rl_in = '0;
  logic [15:0] left, right;
  logic        sample;

  jt51_opacc #(.ACCW(20), .OUTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .op_in(op_in),
    .con_in(con_in), .rl_in(rl_in), .left(left), .right(right), .sample(sample)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int exp_l = 0, exp_r = 0;
  bit exp_pend = 1'b0;
  bit m_locked = 1'b0;
  int m_slot = 0;
  int op_a[32], con_a[32], rl_a[32];

  // Frame stimulus tables
  int f_op[32], f_con[32], f_rl[32];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic bit is_carrier(input int con, input int g);
    if (con <= 3) return g == 3;
    if (con == 4) return g >= 2;
    if (con <= 6) return g >= 1;
    return 1'b1;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void compute_frame();
    int l, r, f;
    l = 0;
    r = 0;
    for (int c = 0; c < 8; c++) begin
      f = 0;
      for (int g = 0; g < 4; g++)
        if (is_carrier(con_a[8*g+c], g)) f += op_a[8*g+c];
      if ((rl_a[24+c] & 2) != 0) l += f;
      if ((rl_a[24+c] & 1) != 0) r += f;
    end
    exp_l = sat16(l);
    exp_r = sat16(r);
  endfunction

  task automatic cyc(input bit z, input int op, input int con, input int rl, input bit c);
    int cur;
    @(negedge clk);
    zero = z;
    op_in = op[13:0];
    con_in = con[2:0];
    rl_in = rl[1:0];
    cen = c;
    @(posedge clk);
    if (c) begin
      exp_pend = 1'b0;
      if (z || m_locked) begin
        m_locked = 1'b1;
        cur = z ? 0 : (m_slot + 1) % 32;
        op_a[cur] = op;
        con_a[cur] = con;
        rl_a[cur] = rl;
        if (cur == 31) begin
          compute_frame();
          exp_pend = 1'b1;
        end
        m_slot = cur;
      end
    end
  endtask

  task automatic fill(input int op, input int con, input int rl);
    for (int s = 0; s < 32; s++) begin
      f_op[s] = op;
      f_con[s] = con;
      f_rl[s] = rl;
    end
  endtask

  // Each slot optionally preceded by two cen=0 cycles
  task automatic send(input bit zf, input int first, input int last, input bit slow);
    for (int s = first; s <= last; s++) begin
      if (slow) begin
        cyc(1'b0, f_op[s], f_con[s], f_rl[s], 1'b0);
        cyc(1'b0, f_op[s], f_con[s], f_rl[s], 1'b0);
      end
      cyc(zf && s == first, f_op[s], f_con[s], f_rl[s], 1'b1);
    end
  endtask

  // Hand-computed expectation right after the slot-31 edge
  task automatic lit(input string nm, input int l, input int r);
    #1;
    chk({nm, "_left"}, int'($signed(left)), l);
    chk({nm, "_right"}, int'($signed(right)), r);
    chk({nm, "_sample"}, int'(sample), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cen = 1'b0;
    zero = 1'b0;
    m_locked = 1'b0;
    m_slot = 0;
    exp_pend = 1'b0;
    exp_l = 0;
    exp_r = 0;
    #1;
    chk("rst_left", int'($signed(left)), 0);
    chk("rst_sample", int'(sample), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    #1;
    chk("cmp_sample", int'(sample), int'(exp_pend & cen));
    chk("cmp_left", int'($signed(left)), exp_l);
    chk("cmp_right", int'($signed(right)), exp_r);
  end

  initial begin
    #1 rst_n = 1'b0;
    do_reset();

    // Not locked: random traffic, no sample
    for (int i = 0; i < 100; i++)
      cyc(1'b0, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    fill(100, 7, 3);
    send(1'b1, 0, 31, 1'b0);
    lit("all100_a", 3200, 3200);
    send(1'b0, 0, 31, 1'b0);
    lit("all100_b", 3200, 3200);
    send(1'b1, 0, 31, 1'b0);
    lit("all100_wrapzero", 3200, 3200);

    fill(0, 0, 2);
    f_op[0] = 1000;
    f_op[8] = 1000;
    f_op[16] = 1000;
    f_op[24] = 500;
    send(1'b0, 0, 31, 1'b0);
    lit("con0_ch0", 500, 0);

    fill(8191, 7, 3);
    send(1'b0, 0, 31, 1'b0);
    lit("sat_pos", 32767, 32767);
    fill(-8192, 7, 3);
    send(1'b0, 0, 31, 1'b0);
    lit("sat_neg", -32768, -32768);

    // Abort at slot 12, then a fresh frame
    fill(50, 7, 3);
    send(1'b0, 0, 11, 1'b0);
    fill(100, 7, 3);
    send(1'b1, 0, 31, 1'b0);
    lit("resync", 3200, 3200);

    fill(0, 4, 1);
    f_op[3] = 77;
    f_op[11] = 55;
    f_op[19] = 10;
    f_op[27] = 20;
    send(1'b0, 0, 31, 1'b1);
    lit("cen_con4", 0, 30);

    // Mid-frame reset: no output until a new zero plus a full frame
    fill(100, 7, 3);
    send(1'b0, 0, 15, 1'b0);
    do_reset();
    send(1'b0, 0, 31, 1'b0);
    send(1'b1, 0, 31, 1'b0);
    lit("after_rst", 3200, 3200);

    cyc(1'b0, 0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 0, 1'b1);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
